// File: rtl/tank_ctrl_param.sv
// Per-player artillery tank controller: keycode-driven terrain-following movement with a per-turn
// fuel budget, edge-triggered aim, single-shot fire/reload FSM, saturating HP and a sticky game-over flag.
module tank_ctrl_param #(
  parameter int          X_START   = 550,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 639,
  parameter int          TANK_SIZE = 4,
  parameter int          Y_OFFSET  = 45,
  parameter int          MOVE_DIV  = 2,
  parameter int          FUEL_MAX  = 120,
  parameter int          AIM_MAX   = 63,
  parameter int          AIM_STEP  = 3,
  parameter int          AIM_INIT  = 0,
  parameter int          HP_MAX    = 10,
  parameter int          DMG_BASE  = 5,
  parameter logic [7:0]  KEY_L     = 8'h0d,
  parameter logic [7:0]  KEY_R     = 8'h0f,
  parameter logic [7:0]  KEY_U     = 8'h0c,
  parameter logic [7:0]  KEY_D     = 8'h0e,
  parameter logic [7:0]  KEY_FIRE  = 8'h28,
  parameter logic [7:0]  KEY_RLD   = 8'h13,
  localparam int         FUEL_W    = $clog2(FUEL_MAX + 1),
  localparam int         AIM_W     = $clog2(AIM_MAX + 1),
  localparam int         HP_W      = $clog2(HP_MAX + 1)
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic [7:0]        keycode,
  input  logic              game_active,
  input  logic              my_turn,
  input  logic              hit,
  input  logic [1:0]        enemy_type,
  input  logic [9:0]        terrain_y,
  output logic [9:0]        TankX,
  output logic [9:0]        TankY,
  output logic [9:0]        TankS,
  output logic              Direction,
  output logic [AIM_W-1:0]  aim,
  output logic              shoot,
  output logic [FUEL_W-1:0] fuel,
  output logic [HP_W-1:0]   HP,
  output logic              GG
);

  localparam int              DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [9:0]      X_LO     = 10'(X_MIN + TANK_SIZE);
  localparam logic [9:0]      X_HI     = 10'(X_MAX - TANK_SIZE);
  localparam logic [9:0]      X_RST    = 10'(X_START);
  localparam logic [9:0]      Y_OFF    = 10'(Y_OFFSET);

  typedef enum logic [1:0] {ST_READY, ST_FIRE, ST_SPENT} fire_state_e;

  fire_state_e       state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dir_q, dir_d, shoot_q, shoot_d, gg_q, gg_d, turn_prev_q, turn_prev_d;
  logic [AIM_W-1:0]  aim_q, aim_d;
  logic [FUEL_W-1:0] fuel_q, fuel_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        key_v, key_prev_q, key_prev_d;
  logic              turn_rise, move_l, move_r, step_now;
  logic              up_edge, down_edge, fire_edge, rld_edge;
  logic [31:0]       dmg;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    key_v      = (game_active && my_turn && !gg_q) ? keycode : 8'h00;
    turn_rise  = my_turn && !turn_prev_q;
    move_l     = (key_v == KEY_L);
    move_r     = (key_v == KEY_R);
    up_edge    = (key_v == KEY_U)    && (key_prev_q != KEY_U);
    down_edge  = (key_v == KEY_D)    && (key_prev_q != KEY_D);
    fire_edge  = (key_v == KEY_FIRE) && (key_prev_q != KEY_FIRE);
    rld_edge   = (key_v == KEY_RLD)  && (key_prev_q != KEY_RLD);
    step_now   = (div_q == DIV_LAST) && (fuel_q != '0);
    dmg        = 32'(DMG_BASE) - 32'(enemy_type);

    x_d         = x_q;
    dir_d       = dir_q;
    aim_d       = aim_q;
    fuel_d      = fuel_q;
    hp_d        = hp_q;
    state_d     = state_q;
    div_d       = '0;
    key_prev_d  = key_v;
    turn_prev_d = my_turn;
    y_d         = (terrain_y >= Y_OFF) ? terrain_y - Y_OFF : '0;

    if (move_l || move_r) begin
      dir_d = move_r;
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      // Blocked steps at the clamp or with an empty tank cost no fuel.
      if (step_now && move_r && (x_q < X_HI)) begin
        x_d    = x_q + 10'd1;
        fuel_d = fuel_q - 1'b1;
      end else if (step_now && move_l && (x_q > X_LO)) begin
        x_d    = x_q - 10'd1;
        fuel_d = fuel_q - 1'b1;
      end
    end
    if (turn_rise) fuel_d = FUEL_W'(FUEL_MAX);

    if (up_edge)
      aim_d = (32'(aim_q) + 32'(AIM_STEP) >= 32'(AIM_MAX)) ? AIM_W'(AIM_MAX)
                                                           : AIM_W'(32'(aim_q) + 32'(AIM_STEP));
    else if (down_edge)
      aim_d = (32'(aim_q) <= 32'(AIM_STEP)) ? '0 : AIM_W'(32'(aim_q) - 32'(AIM_STEP));

    case (state_q)
      ST_READY: if (fire_edge) state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_SPENT;
      ST_SPENT: if (rld_edge || turn_rise) state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase

    // GG looks at the registered HP, so it rises one frame after HP reaches zero.
    gg_d = gg_q || (hp_q == '0);
    if (hit && !gg_q)
      hp_d = (32'(hp_q) > dmg) ? HP_W'(32'(hp_q) - dmg) : '0;

    if (!game_active) begin
      hp_d    = HP_W'(HP_MAX);
      gg_d    = 1'b0;
      fuel_d  = FUEL_W'(FUEL_MAX);
      aim_d   = AIM_W'(AIM_INIT);
      x_d     = X_RST;
      state_d = ST_READY;
    end

    shoot_d = (state_d == ST_FIRE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_READY;
      x_q         <= X_RST;
      y_q         <= '0;
      dir_q       <= 1'b0;
      aim_q       <= AIM_W'(AIM_INIT);
      shoot_q     <= 1'b0;
      fuel_q      <= FUEL_W'(FUEL_MAX);
      hp_q        <= HP_W'(HP_MAX);
      gg_q        <= 1'b0;
      div_q       <= '0;
      key_prev_q  <= 8'h00;
      turn_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      aim_q       <= aim_d;
      shoot_q     <= shoot_d;
      fuel_q      <= fuel_d;
      hp_q        <= hp_d;
      gg_q        <= gg_d;
      div_q       <= div_d;
      key_prev_q  <= key_prev_d;
      turn_prev_q <= turn_prev_d;
    end
  end

  assign TankX     = x_q;
  assign TankY     = y_q;
  assign TankS     = 10'(TANK_SIZE);
  assign Direction = dir_q;
  assign aim       = aim_q;
  assign shoot     = shoot_q;
  assign fuel      = fuel_q;
  assign HP        = hp_q;
  assign GG        = gg_q;

endmodule

// File: tb/tb_tank_ctrl_param.sv
// Self-checking bench for tank_ctrl_param: directed vector table, hand-written multi-cycle
// sequences and randomized frames checked against an arithmetic reference model.
module tb_tank_ctrl_param;

  localparam logic [7:0] KL = 8'h0d, KR = 8'h0f, KU = 8'h0c, KD = 8'h0e, KF = 8'h28, KRLD = 8'h13;
  localparam int MOVE_DIV = 2, FUEL_MAX = 120, HP_MAX = 10, X_START = 550;
  localparam int X_LO = 4, X_HI = 635, Y_OFF = 45, AIM_MAX = 63, AIM_STEP = 3, DMG_BASE = 5;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       game_active, my_turn, hit;
  logic [1:0] enemy_type;
  logic [9:0] terrain_y;
  logic [9:0] tank_x, tank_y, tank_s;
  logic       direction, shoot, gg;
  logic [5:0] aim;
  logic [6:0] fuel;
  logic [3:0] hp;

  int n_cmp = 0;
  int n_mis = 0;

  tank_ctrl_param dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .game_active(game_active),
    .my_turn(my_turn), .hit(hit), .enemy_type(enemy_type), .terrain_y(terrain_y),
    .TankX(tank_x), .TankY(tank_y), .TankS(tank_s), .Direction(direction), .aim(aim),
    .shoot(shoot), .fuel(fuel), .HP(hp), .GG(gg)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers; "armed" means a shot is available, hold counts held move frames.
  int m_x, m_y, m_dir, m_aim, m_shoot, m_fuel, m_hp, m_gg, m_hold, m_armed, m_kprev, m_mtprev;

  task automatic model_reset();
    m_x = X_START; m_y = 0; m_dir = 0; m_aim = 0; m_shoot = 0; m_fuel = FUEL_MAX;
    m_hp = HP_MAX; m_gg = 0; m_hold = 0; m_armed = 1; m_kprev = 0; m_mtprev = 0;
  endtask

  function automatic bit pressed(input int kv, input int k);
    return (kv == k) && (m_kprev != k);
  endfunction

  task automatic model_step();
    int kv, new_gg;
    bit rise, was_firing;
    kv = (game_active && my_turn && m_gg == 0) ? int'(keycode) : 0;
    rise = my_turn && (m_mtprev == 0);
    was_firing = (m_shoot != 0);
    m_y = (int'(terrain_y) > Y_OFF) ? int'(terrain_y) - Y_OFF : 0;
    if (!game_active) begin
      m_hp = HP_MAX; m_gg = 0; m_fuel = FUEL_MAX; m_aim = 0; m_x = X_START;
      m_hold = 0; m_shoot = 0; m_armed = 1;
    end else begin
      if (kv == KL || kv == KR) begin
        m_dir = (kv == KR);
        m_hold++;
        if (m_hold % MOVE_DIV == 0 && m_fuel > 0) begin
          if (kv == KR && m_x < X_HI) begin m_x++; m_fuel--; end
          else if (kv == KL && m_x > X_LO) begin m_x--; m_fuel--; end
        end
      end else m_hold = 0;
      if (rise) m_fuel = FUEL_MAX;
      if (pressed(kv, KU)) m_aim = (m_aim + AIM_STEP > AIM_MAX) ? AIM_MAX : m_aim + AIM_STEP;
      if (pressed(kv, KD)) m_aim = (m_aim - AIM_STEP < 0) ? 0 : m_aim - AIM_STEP;
      m_shoot = (m_armed != 0) && pressed(kv, KF);
      if (m_shoot != 0) m_armed = 0;
      else if (!was_firing && (pressed(kv, KRLD) || rise)) m_armed = 1;
      new_gg = (m_gg != 0 || m_hp == 0);
      if (hit && m_gg == 0) begin
        m_hp = m_hp - (DMG_BASE - int'(enemy_type));
        if (m_hp < 0) m_hp = 0;
      end
      m_gg = new_gg;
    end
    m_kprev = kv;
    m_mtprev = my_turn;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x"}, tank_x, m_x);
    check({tag, ".y"}, tank_y, m_y);
    check({tag, ".dir"}, direction, m_dir);
    check({tag, ".aim"}, aim, m_aim);
    check({tag, ".shoot"}, shoot, m_shoot);
    check({tag, ".fuel"}, fuel, m_fuel);
    check({tag, ".hp"}, hp, m_hp);
    check({tag, ".gg"}, gg, m_gg);
  endtask

  task automatic step(input string tag);
    @(posedge frame_clk);
    #1;
    model_step();
    compare_all(tag);
  endtask

  typedef struct {
    logic [7:0] key;
    bit mt, ga, hit;
    int et, terr, reps;
    int x, y, dir, aim, shoot, fuel, hp, gg;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // key mt ga hit et terr reps | x y dir aim shoot fuel hp gg
    vecs.push_back('{KL,   1,1,0,0,100,10, 545,55,0,0,0,115,10,0});
    vecs.push_back('{KR,   1,1,0,0,100, 1, 545,55,1,0,0,115,10,0});
    vecs.push_back('{KR,   1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{8'h00,1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KU,   1,1,0,0,100, 5, 546,55,1,3,0,114,10,0});
    vecs.push_back('{8'h00,1,1,0,0,100, 1, 546,55,1,3,0,114,10,0});
    vecs.push_back('{KD,   1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KD,   1,1,0,0,100, 2, 546,55,1,0,0,114,10,0});
    vecs.push_back('{8'h00,1,1,0,0, 30, 1, 546, 0,1,0,0,114,10,0});
    vecs.push_back('{KD,   1,1,0,0, 46, 1, 546, 1,1,0,0,114,10,0});
    vecs.push_back('{KF,   1,1,0,0, 45, 1, 546, 0,1,0,1,114,10,0});
    vecs.push_back('{KF,   1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{8'h00,1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KF,   1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KRLD, 1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KF,   1,1,0,0,100, 1, 546,55,1,0,1,114,10,0});
    vecs.push_back('{8'h00,1,1,0,0,100, 1, 546,55,1,0,0,114,10,0});
    vecs.push_back('{KU,   1,1,0,0,100, 1, 546,55,1,3,0,114,10,0});
    vecs.push_back('{8'h00,1,1,1,0,100, 1, 546,55,1,3,0,114, 5,0});
    vecs.push_back('{8'h00,1,1,1,3,100, 1, 546,55,1,3,0,114, 3,0});
    vecs.push_back('{8'h00,1,1,1,0,100, 1, 546,55,1,3,0,114, 0,0});
    vecs.push_back('{8'h00,1,1,0,0,100, 1, 546,55,1,3,0,114, 0,1});
    vecs.push_back('{KL,   1,1,0,0,100, 4, 546,55,1,3,0,114, 0,1});
    vecs.push_back('{KU,   1,1,1,0,100, 1, 546,55,1,3,0,114, 0,1});
    vecs.push_back('{8'h00,1,0,0,0,100, 1, 550,55,1,0,0,120,10,0});
    vecs.push_back('{KL,   1,1,0,0,100, 1, 550,55,0,0,0,120,10,0});

    keycode = 8'h00; game_active = 1'b1; my_turn = 1'b1; hit = 1'b0;
    enemy_type = 2'd0; terrain_y = 10'd100;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    check("reset.tank_s", tank_s, 4);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      keycode = vecs[i].key; my_turn = vecs[i].mt; game_active = vecs[i].ga;
      hit = vecs[i].hit; enemy_type = 2'(vecs[i].et); terrain_y = 10'(vecs[i].terr);
      repeat (vecs[i].reps) step($sformatf("row%0d.model", i));
      check($sformatf("row%0d.x", i), tank_x, vecs[i].x);
      check($sformatf("row%0d.y", i), tank_y, vecs[i].y);
      check($sformatf("row%0d.dir", i), direction, vecs[i].dir);
      check($sformatf("row%0d.aim", i), aim, vecs[i].aim);
      check($sformatf("row%0d.shoot", i), shoot, vecs[i].shoot);
      check($sformatf("row%0d.fuel", i), fuel, vecs[i].fuel);
      check($sformatf("row%0d.hp", i), hp, vecs[i].hp);
      check($sformatf("row%0d.gg", i), gg, vecs[i].gg);
    end
    hit = 1'b0; enemy_type = 2'd0; terrain_y = 10'd100;

    // Fuel exhaustion and refill on my_turn rising edge.
    keycode = 8'h00; my_turn = 1'b0; step("fuel.turn_lo");
    my_turn = 1'b1; step("fuel.turn_hi");
    check("fuel.refill0", fuel, 120);
    keycode = KL; repeat (238) step("fuel.left");
    check("fuel.left_x", tank_x, 431);
    check("fuel.left_fuel", fuel, 1);
    keycode = KR; repeat (2) step("fuel.right");
    check("fuel.last_x", tank_x, 432);
    check("fuel.last_fuel", fuel, 0);
    repeat (6) step("fuel.frozen");
    check("fuel.frozen_x", tank_x, 432);
    check("fuel.frozen_fuel", fuel, 0);
    keycode = 8'h00; my_turn = 1'b0; step("fuel.turn_lo2");
    my_turn = 1'b1; step("fuel.turn_hi2");
    check("fuel.refill1", fuel, 120);

    // Right clamp: blocked steps spend no fuel.
    game_active = 1'b0; step("clamp.newgame");
    game_active = 1'b1; keycode = KR;
    repeat (200) step("clamp.right");
    check("clamp.x", tank_x, 635);
    check("clamp.fuel", fuel, 35);
    keycode = 8'h00; step("clamp.release");

    // Aim saturation in both directions.
    for (int i = 0; i < 30; i++) begin
      keycode = KU; step("aim.up"); keycode = 8'h00; step("aim.up_rel");
    end
    check("aim.max", aim, 63);
    for (int i = 0; i < 22; i++) begin
      keycode = KD; step("aim.dn"); keycode = 8'h00; step("aim.dn_rel");
    end
    check("aim.min", aim, 0);

    // Fire is ignored when it is not this player's turn.
    my_turn = 1'b0; keycode = KF;
    step("noturn.f0"); check("noturn.shoot0", shoot, 0);
    step("noturn.f1"); check("noturn.shoot1", shoot, 0);
    keycode = 8'h00; my_turn = 1'b1; step("noturn.back");

    // Asynchronous reset in the middle of a FIRE pulse.
    keycode = KF; step("rst.fire");
    check("rst.fire_pulse", shoot, 1);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    check("rst.async_shoot", shoot, 0);
    compare_all("rst.async");
    @(posedge frame_clk); #1;
    compare_all("rst.held");
    keycode = 8'h00;
    @(negedge frame_clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("rst.after");
      check($sformatf("rst.no_pulse%0d", i), shoot, 0);
    end

    // Randomized frames against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 7))
          0: keycode = 8'h00;
          1: keycode = KL;
          2: keycode = KR;
          3: keycode = KU;
          4: keycode = KD;
          5: keycode = KF;
          6: keycode = KRLD;
          default: keycode = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 39) == 0) my_turn = ~my_turn;
      game_active = ($urandom_range(0, 149) != 0);
      hit = ($urandom_range(0, 24) == 0);
      enemy_type = 2'($urandom_range(0, 3));
      terrain_y = 10'($urandom_range(0, 300));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
